// File: rtl/dmem_ahb_slave.sv
// AHB-Lite data-memory slave: single transfers, configurable wait states, read-after-write forwarding.
// Define DMEM_ERR_CHECK_EN to answer illegal transfers with a two-cycle ERROR; otherwise they are aligned down.
module dmem_ahb_slave #(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  hsel,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [1:0]            htrans,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [31:0]           hwdata,
    input  logic                  hready_in,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [31:0]           hrdata,
    output logic [2:0]            dbg_state
);
    localparam int         WORDS     = 2 ** (ADDR_WIDTH - 2);
    localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-3:0] idx_q, idx_d;
    logic                  write_q, write_d;
    logic [3:0]            be_q, be_d;
    logic                  fwd_q, fwd_d;
    logic [31:0]           fwd_data_q, fwd_data_d;
    logic [3:0]            fwd_be_q, fwd_be_d;
    logic [31:0]           hrdata_q, hrdata_d;
    logic [31:0]           mem_rdata_q;
    logic [31:0]           mem [WORDS];

    logic                  accept;
    logic                  illegal;
    logic                  commit;
    logic                  rd_issue;
    logic [1:0]            size_eff;
    logic [3:0]            be_new;
    logic [31:0]           merged;
    logic [ADDR_WIDTH-3:0] haddr_idx;
    logic                  unused_inputs;

    // Handshake: an address phase is taken only on a cycle where hsel, htrans[1] and
    // hready_in are high and this slave is itself ready; the data phase completes on the
    // first cycle with hreadyout high, and that same cycle may take the next address phase.
    assign unused_inputs = ^{hburst, htrans[0]};
    assign haddr_idx     = haddr[ADDR_WIDTH-1:2];
    assign accept        = hsel && htrans[1] && hready_in && hreadyout;
    assign commit        = (state_q == ST_DATA) && write_q;
    assign dbg_state     = state_q;
    assign hrdata        = hrdata_d;

`ifdef DMEM_ERR_CHECK_EN
    assign hreadyout = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

    always_comb begin
        illegal  = 1'b0;
        size_eff = hsize[1:0];
        if (hsize > 3'd2) begin
            illegal = 1'b1;
        end else if ((hsize == 3'd1) && haddr[0]) begin
            illegal = 1'b1;
        end else if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) begin
            illegal = 1'b1;
        end
    end
`else
    assign hreadyout = (state_q != ST_WAIT);
    assign hresp     = 1'b0;

    // Oversized transfers become word accesses; low address bits are ignored by the lane decode.
    always_comb begin
        illegal  = 1'b0;
        size_eff = (hsize > 3'd2) ? 2'd2 : hsize[1:0];
    end
`endif

    always_comb begin
        be_new = 4'hF;
        case (size_eff)
            2'd0:    be_new = 4'b0001 << haddr[1:0];
            2'd1:    be_new = haddr[1] ? 4'b1100 : 4'b0011;
            default: be_new = 4'hF;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = (fwd_q && fwd_be_q[i]) ? fwd_data_q[8*i +: 8] : mem_rdata_q[8*i +: 8];
        end
        hrdata_d = ((state_q == ST_DATA) && !write_q) ? merged : hrdata_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        write_d    = write_q;
        be_d       = be_q;
        fwd_d      = fwd_q;
        fwd_data_d = fwd_data_q;
        fwd_be_d   = fwd_be_q;
        rd_issue   = 1'b0;
        if (!hreadyout) begin
            if (state_q == ST_WAIT) begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end else begin
                state_d = ST_ERR2;
            end
        end else begin
            state_d = ST_IDLE;
            if (accept) begin
                idx_d   = haddr_idx;
                write_d = hwrite;
                be_d    = be_new;
                if (illegal) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
                    cnt_d   = WAIT_INIT;
                    if (!hwrite) begin
                        // The array is read-first, so a write retiring this edge must be merged later.
                        rd_issue   = 1'b1;
                        fwd_d      = commit && (idx_q == haddr_idx);
                        fwd_data_d = hwdata;
                        fwd_be_d   = be_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            be_q       <= 4'h0;
            fwd_q      <= 1'b0;
            fwd_data_q <= 32'h0;
            fwd_be_q   <= 4'h0;
            hrdata_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            be_q       <= be_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
            fwd_be_q   <= fwd_be_d;
            hrdata_q   <= hrdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
        if (rd_issue) begin
            mem_rdata_q <= mem[haddr_idx];
        end
    end
endmodule

// File: tb/tb_dmem_ahb_slave.sv
// Bench for dmem_ahb_slave: one instance with no wait states, one with two; follows DMEM_ERR_CHECK_EN.
module tb_dmem_ahb_slave;
    localparam int AW = 14;

`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic          hsel_s      [2];
    logic          hwrite_s    [2];
    logic [2:0]    hsize_s     [2];
    logic [2:0]    hburst_s    [2];
    logic [1:0]    htrans_s    [2];
    logic [AW-1:0] haddr_s     [2];
    logic [31:0]   hwdata_s    [2];
    logic          hreadyout_s [2];
    logic          hresp_s     [2];
    logic [31:0]   hrdata_s    [2];
    logic [2:0]    dbg_s       [2];

    int n_checks = 0;
    int n_errors = 0;

    dmem_ahb_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .rstn(rstn), .hsel(hsel_s[0]), .hwrite(hwrite_s[0]), .hsize(hsize_s[0]),
        .hburst(hburst_s[0]), .htrans(htrans_s[0]), .haddr(haddr_s[0]), .hwdata(hwdata_s[0]),
        .hready_in(hreadyout_s[0]), .hreadyout(hreadyout_s[0]), .hresp(hresp_s[0]),
        .hrdata(hrdata_s[0]), .dbg_state(dbg_s[0])
    );

    dmem_ahb_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) u_dut_ws2 (
        .clk(clk), .rstn(rstn), .hsel(hsel_s[1]), .hwrite(hwrite_s[1]), .hsize(hsize_s[1]),
        .hburst(hburst_s[1]), .htrans(htrans_s[1]), .haddr(haddr_s[1]), .hwdata(hwdata_s[1]),
        .hready_in(hreadyout_s[1]), .hreadyout(hreadyout_s[1]), .hresp(hresp_s[1]),
        .hrdata(hrdata_s[1]), .dbg_state(dbg_s[1])
    );

    typedef struct {
        logic          wr;
        logic [2:0]    size;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
        int            exp_waits;
        logic          exp_err;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic addr_phase(input int idx, input logic wr, input logic [2:0] size,
                              input logic [AW-1:0] addr, input logic [1:0] trans, input logic sel);
        hsel_s[idx]   = sel;
        hwrite_s[idx] = wr;
        hsize_s[idx]  = size;
        htrans_s[idx] = trans;
        haddr_s[idx]  = addr;
        hburst_s[idx] = 3'($urandom_range(0, 7));
    endtask

    task automatic idle_bus(input int idx);
        hsel_s[idx]   = 1'b0;
        hwrite_s[idx] = 1'b0;
        hsize_s[idx]  = 3'd0;
        htrans_s[idx] = 2'b00;
    endtask

    // Called just after a clock edge; returns on the first negedge with hreadyout high.
    task automatic wait_ready(input int idx, input logic exp_low_resp, input string name, output int waits);
        waits = 0;
        @(negedge clk);
        while (hreadyout_s[idx] !== 1'b1 && waits < 16) begin
            chk({name, "_low_hresp"}, 32'(hresp_s[idx]), 32'(exp_low_resp));
            waits++;
            @(negedge clk);
        end
        chk({name, "_hreadyout"}, 32'(hreadyout_s[idx]), 32'd1);
    endtask

    task automatic xfer(input int idx, input logic wr, input logic [2:0] size, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input int exp_waits,
                        input logic exp_err, input string name);
        int waits;
        addr_phase(idx, wr, size, addr, 2'b10, 1'b1);
        @(posedge clk); #1;
        idle_bus(idx);
        hwdata_s[idx] = wdata;
        wait_ready(idx, exp_err, name, waits);
        chk({name, "_waits"}, 32'(waits), 32'(exp_waits));
        chk({name, "_hresp"}, 32'(hresp_s[idx]), 32'(exp_err));
        if (!wr && !exp_err) chk({name, "_hrdata"}, hrdata_s[idx], exp_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int waits;
        vecs[0]  = '{1'b1, 3'd2, 14'h0010, 32'hDEADBEEF, 32'h0,        0, 1'b0};
        vecs[1]  = '{1'b0, 3'd2, 14'h0010, 32'h0,        32'hDEADBEEF, 0, 1'b0};
        vecs[2]  = '{1'b1, 3'd1, 14'h0012, 32'h55AA55AA, 32'h0,        0, 1'b0};
        vecs[3]  = '{1'b0, 3'd1, 14'h0012, 32'h0,        32'h55AABEEF, 0, 1'b0};
        vecs[4]  = '{1'b1, 3'd0, 14'h0010, 32'h77777777, 32'h0,        0, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 14'h0011, 32'h0,        32'h55AABE77, 0, 1'b0};
        vecs[6]  = '{1'b1, 3'd2, 14'h3FFC, 32'hCAFEF00D, 32'h0,        0, 1'b0};
        vecs[7]  = '{1'b0, 3'd2, 14'h3FFC, 32'h0,        32'hCAFEF00D, 0, 1'b0};
        vecs[8]  = '{1'b1, 3'd2, 14'h0000, 32'h00000000, 32'h0,        0, 1'b0};
        if (ERR_EN) begin
            vecs[9]  = '{1'b1, 3'd1, 14'h0003, 32'hBEEFBEEF, 32'h0,        1, 1'b1};
            vecs[10] = '{1'b0, 3'd2, 14'h0000, 32'h0,        32'h00000000, 0, 1'b0};
            vecs[11] = '{1'b0, 3'd3, 14'h0010, 32'h0,        32'h0,        1, 1'b1};
            vecs[12] = '{1'b0, 3'd2, 14'h0012, 32'h0,        32'h0,        1, 1'b1};
        end else begin
            vecs[9]  = '{1'b1, 3'd1, 14'h0003, 32'hBEEFBEEF, 32'h0,        0, 1'b0};
            vecs[10] = '{1'b0, 3'd2, 14'h0000, 32'h0,        32'hBEEF0000, 0, 1'b0};
            vecs[11] = '{1'b0, 3'd3, 14'h0010, 32'h0,        32'h55AABE77, 0, 1'b0};
            vecs[12] = '{1'b0, 3'd2, 14'h0012, 32'h0,        32'h55AABE77, 0, 1'b0};
        end
        vecs[13] = '{1'b1, 3'd2, 14'h0020, 32'h11223344, 32'h0,        0, 1'b0};
        vecs[14] = '{1'b0, 3'd2, 14'h0020, 32'h0,        32'h11223344, 0, 1'b0};

        // Clock/reset
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            idle_bus(k);
            haddr_s[k]  = '0;
            hwdata_s[k] = 32'h0;
            hburst_s[k] = 3'd0;
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_hreadyout", k), 32'(hreadyout_s[k]), 32'd1);
            chk($sformatf("rst%0d_hresp", k), 32'(hresp_s[k]), 32'd0);
            chk($sformatf("rst%0d_hrdata", k), hrdata_s[k], 32'h0);
            chk($sformatf("rst%0d_state", k), 32'(dbg_s[k]), 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;

        // Table vectors, zero-wait instance
        for (int i = 0; i < NVEC; i++) begin
            xfer(0, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                 vecs[i].exp_waits, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // BUSY and unselected NONSEQ must not touch memory
        addr_phase(0, 1'b1, 3'd2, 14'h0010, 2'b01, 1'b1);
        @(posedge clk); #1;
        hwdata_s[0] = 32'hFFFFFFFF;
        addr_phase(0, 1'b1, 3'd2, 14'h0010, 2'b10, 1'b0);
        @(negedge clk);
        chk("busy_hreadyout", 32'(hreadyout_s[0]), 32'd1);
        chk("busy_hresp", 32'(hresp_s[0]), 32'd0);
        @(posedge clk); #1;
        idle_bus(0);
        @(negedge clk);
        chk("nosel_hreadyout", 32'(hreadyout_s[0]), 32'd1);
        chk("nosel_hresp", 32'(hresp_s[0]), 32'd0);
        @(posedge clk); #1;
        xfer(0, 1'b0, 3'd2, 14'h0010, 32'h0, 32'h55AABE77, 0, 1'b0, "busy_mem");

        // Back-to-back write byte then read word, zero waits: forwarded bytes
        addr_phase(0, 1'b1, 3'd0, 14'h0021, 2'b10, 1'b1);
        @(posedge clk); #1;
        hwdata_s[0] = 32'hA5A5A5A5;
        addr_phase(0, 1'b0, 3'd2, 14'h0020, 2'b11, 1'b1);
        @(negedge clk);
        chk("fwd0_wr_ready", 32'(hreadyout_s[0]), 32'd1);
        @(posedge clk); #1;
        idle_bus(0);
        @(negedge clk);
        chk("fwd0_rd_ready", 32'(hreadyout_s[0]), 32'd1);
        chk("fwd0_rd_hresp", 32'(hresp_s[0]), 32'd0);
        chk("fwd0_rd_hrdata", hrdata_s[0], 32'h1122A544);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fwd0_hold_hrdata", hrdata_s[0], 32'h1122A544);
        @(posedge clk); #1;
        xfer(0, 1'b0, 3'd2, 14'h0020, 32'h0, 32'h1122A544, 0, 1'b0, "fwd0_commit");

        // Two-wait instance: basic write/read
        xfer(1, 1'b1, 3'd2, 14'h0040, 32'h12345678, 32'h0, 2, 1'b0, "ws2_wr40");
        xfer(1, 1'b0, 3'd2, 14'h0040, 32'h0, 32'h12345678, 2, 1'b0, "ws2_rd40");

        // Read, with the next write address held so it is taken on the read's data cycle
        addr_phase(1, 1'b0, 3'd2, 14'h0040, 2'b10, 1'b1);
        @(posedge clk); #1;
        addr_phase(1, 1'b1, 3'd2, 14'h0044, 2'b10, 1'b1);
        wait_ready(1, 1'b0, "pipe_rd", waits);
        chk("pipe_rd_waits", 32'(waits), 32'd2);
        chk("pipe_rd_hrdata", hrdata_s[1], 32'h12345678);
        @(posedge clk); #1;
        idle_bus(1);
        hwdata_s[1] = 32'h9ABCDEF0;
        wait_ready(1, 1'b0, "pipe_wr", waits);
        chk("pipe_wr_waits", 32'(waits), 32'd2);
        chk("pipe_wr_hresp", 32'(hresp_s[1]), 32'd0);
        @(posedge clk); #1;
        xfer(1, 1'b0, 3'd2, 14'h0044, 32'h0, 32'h9ABCDEF0, 2, 1'b0, "pipe_rd44");

        // Forwarding with wait states
        addr_phase(1, 1'b1, 3'd0, 14'h0041, 2'b10, 1'b1);
        @(posedge clk); #1;
        hwdata_s[1] = 32'hA5A5A5A5;
        addr_phase(1, 1'b0, 3'd2, 14'h0040, 2'b10, 1'b1);
        wait_ready(1, 1'b0, "fwd2_wr", waits);
        chk("fwd2_wr_waits", 32'(waits), 32'd2);
        @(posedge clk); #1;
        idle_bus(1);
        wait_ready(1, 1'b0, "fwd2_rd", waits);
        chk("fwd2_rd_waits", 32'(waits), 32'd2);
        chk("fwd2_rd_hrdata", hrdata_s[1], 32'h1234A578);
        @(posedge clk); #1;

        // Reset in the middle of a write's wait states
        xfer(1, 1'b1, 3'd2, 14'h0080, 32'h0BADF00D, 32'h0, 2, 1'b0, "rst_pre_wr");
        addr_phase(1, 1'b1, 3'd2, 14'h0080, 2'b10, 1'b1);
        @(posedge clk); #1;
        idle_bus(1);
        hwdata_s[1] = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rst_mid_wait_low", 32'(hreadyout_s[1]), 32'd0);
        rstn = 1'b0;
        #1;
        chk("rst_mid_hreadyout", 32'(hreadyout_s[1]), 32'd1);
        chk("rst_mid_hresp", 32'(hresp_s[1]), 32'd0);
        chk("rst_mid_hrdata", hrdata_s[1], 32'h0);
        chk("rst_mid_state", 32'(dbg_s[1]), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        xfer(1, 1'b0, 3'd2, 14'h0080, 32'h0, 32'h0BADF00D, 2, 1'b0, "rst_post_rd");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
